ring_buffer_ctrl: RTL

- Sequencing controller for one ring buffer in the convolution accelerator's input path.
- Accepts a transfer of N data sets from the upstream loader, gates the buffer's write and read enables, and prefills before streaming.
- Presents buffer output to the PE array with a valid/ready handshake, and reports busy/done to the top-level sequencer.
- The ring buffer's data path (din/dout) is wired directly between loader, buffer and PE array; this block drives control only.

---
 rtl/ring_buffer_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/ring_buffer_ctrl.sv
// Ring buffer sequencing controller for the convolution input path.
// Takes a transfer of num_sets sets from the loader, gates the buffer
// write/read enables, prefills the buffer before it starts streaming, and
// hands sets to the PE array over a valid/ready handshake. Only control
// signals pass through this block; din/dout bypass it.
module ring_buffer_ctrl #(
  parameter int BUFFER_SIZE = 4,
  parameter int PREFILL     = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] num_sets,
  output logic                 busy,
  output logic                 done,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 buf_wen,
  output logic                 buf_ren,
  input  logic                 buf_full,
  input  logic                 buf_empty,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic [CNT_WIDTH-1:0] level
);

  // The buffer keeps one slot free, so the prefill can never exceed its
  // usable capacity.
  localparam int CAPACITY = BUFFER_SIZE - 1;
  localparam int PF_CAP   = (PREFILL < CAPACITY) ? PREFILL : CAPACITY;
  localparam logic [CNT_WIDTH-1:0] PF_LIM = CNT_WIDTH'(PF_CAP);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [CNT_WIDTH-1:0] r_total;
  logic [CNT_WIDTH-1:0] r_wr_cnt;
  logic [CNT_WIDTH-1:0] r_rd_cnt;
  logic                 r_out_valid;

  logic                 w_start_ok;
  logic                 w_in_ready;
  logic                 w_wen;
  logic                 w_ren;
  logic                 w_hs;
  logic [CNT_WIDTH-1:0] w_prefill;
  logic [CNT_WIDTH-1:0] w_wr_next;

  // Enables and handshake, decoded straight from state and buffer flags.
  // An asynchronous reset forces r_state to IDLE, which drives all of these low.
  assign w_start_ok = (r_state == S_IDLE) && start;
  assign w_in_ready = ((r_state == S_FILL) || (r_state == S_STREAM)) &&
                      !buf_full && (r_wr_cnt < r_total);
  assign w_wen      = in_valid && w_in_ready;
  // A pop while the PE holds off would overwrite dout, so a pending set
  // must be consumed (or consumed in this same cycle) before the next pop.
  assign w_ren      = ((r_state == S_STREAM) || (r_state == S_DRAIN)) &&
                      !buf_empty && (r_rd_cnt < r_total) &&
                      (!r_out_valid || out_ready);
  assign w_hs       = r_out_valid && out_ready;
  assign w_prefill  = (r_total < PF_LIM) ? r_total : PF_LIM;
  assign w_wr_next  = r_wr_cnt + {{(CNT_WIDTH-1){1'b0}}, w_wen};

  assign in_ready  = w_in_ready;
  assign buf_wen   = w_wen;
  assign buf_ren   = w_ren;
  assign out_valid = r_out_valid;
  // Sets are popped in order, so the set on dout is number r_rd_cnt.
  assign out_last  = r_out_valid && (r_rd_cnt == r_total);
  assign busy      = (r_state == S_FILL) || (r_state == S_STREAM) ||
                     (r_state == S_DRAIN);
  assign done      = (r_state == S_DONE);
  assign level     = r_wr_cnt - r_rd_cnt;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: registers take non-blocking assignments so every flop samples
    // pre-edge values regardless of the order in which blocks are evaluated.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state decode.
  always_comb begin
    // NOTE: the default comes first so that a path missing an assignment
    // holds the current state instead of inferring a latch.
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:   if (start) w_next_state = (num_sets == '0) ? S_DONE : S_FILL;
      S_FILL:   if (w_wr_next >= w_prefill) w_next_state = S_STREAM;
      S_STREAM: if (r_wr_cnt == r_total) w_next_state = S_DRAIN;
      S_DRAIN:  if ((r_rd_cnt == r_total) && w_hs) w_next_state = S_DONE;
      S_DONE:   w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Transfer length and the write/read set counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_total  <= '0;
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
    end else if (w_start_ok) begin
      r_total  <= num_sets;
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
    end else begin
      if (w_wen) r_wr_cnt <= w_wr_next;
      if (w_ren) r_rd_cnt <= r_rd_cnt + 1'b1;
    end
  end

  // out_valid follows the pop by one cycle, matching the buffer's dout
  // latency. It stays set across a handshake that coincides with a new pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_out_valid <= 1'b0;
    else if (w_ren) r_out_valid <= 1'b1;
    else if (w_hs)  r_out_valid <= 1'b0;
  end

endmodule
